// File: rtl/pacman_pkg.sv
// Shared types for the pacman/ghost movers: headings, keycodes, mover FSM states
// and the one-step target calculation used by every mover.
package pacman_pkg;

  typedef enum logic [1:0] {LEFT, RIGHT, DOWN, UP} dir_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  typedef enum logic [1:0] {IDLE, Q_PEND, Q_HEAD, COMMIT} mover_state_t;

  typedef struct packed {
    logic       oob;
    logic [9:0] x;
    logic [9:0] y;
  } target_t;

  // Upper-bound checks use an 11-bit sum so x+STEP cannot wrap past X_MAX.
  function automatic target_t step_target(input logic [9:0]  x,
                                          input logic [9:0]  y,
                                          input dir_t        d,
                                          input logic [9:0]  step,
                                          input logic [10:0] x_max,
                                          input logic [10:0] y_max);
    target_t     t;
    logic [10:0] sum_x;
    logic [10:0] sum_y;
    sum_x = {1'b0, x} + {1'b0, step};
    sum_y = {1'b0, y} + {1'b0, step};
    t.x   = x;
    t.y   = y;
    t.oob = 1'b0;
    case (d)
      LEFT:  begin t.x = x - step;    t.oob = (x < step);      end
      RIGHT: begin t.x = sum_x[9:0];  t.oob = (sum_x > x_max); end
      DOWN:  begin t.y = sum_y[9:0];  t.oob = (sum_y > y_max); end
      UP:    begin t.y = y - step;    t.oob = (y < step);      end
      default: t.oob = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ghost_mover_if.sv
// Wall-lookup request/acknowledge channel between a mover and the maze lookup.
interface ghost_mover_if;
  logic       query_req;
  logic [9:0] query_x;
  logic [9:0] query_y;
  logic       query_ack;
  logic       query_blocked;

  modport master (output query_req, query_x, query_y,
                  input  query_ack, query_blocked);
  modport slave  (input  query_req, query_x, query_y,
                  output query_ack, query_blocked);
endinterface

// File: rtl/dir_decode.sv
// Keycode to heading decoder, shared by the keyboard-driven and ghost movers.
module dir_decode
  import pacman_pkg::*;
(
  input  logic [7:0] code,
  output logic       valid,
  output dir_t       dir
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    valid = 1'b1;
    dir   = LEFT;
    case (code)
      KEY_LEFT:  dir = LEFT;
      KEY_RIGHT: dir = RIGHT;
      KEY_DOWN:  dir = DOWN;
      KEY_UP:    dir = UP;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ghost_mover.sv
// Ghost sprite mover: once per frame tick, tries the pending heading, falls back
// to the current heading, and commits a step only where the maze lookup says open.
module ghost_mover
  import pacman_pkg::*;
#(
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int STEP   = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [7:0]           dir,
  ghost_mover_if.master        q,
  output logic [9:0]           pos_x,
  output logic [9:0]           pos_y,
  output dir_t                 heading,
  output logic                 moving
);

  localparam logic [9:0]  STEP_W  = 10'(STEP);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

  mover_state_t state_q, state_d;
  dir_t         pending_q, pending_d;
  dir_t         heading_q, heading_d;
  dir_t         qdir_q, qdir_d;
  logic [9:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]   qx_q, qx_d, qy_q, qy_d;
  logic         req_q, req_d;
  logic         moving_q, moving_d;

  logic         dec_valid;
  dir_t         dec_dir;
  target_t      pend_tgt, head_tgt;

  dir_decode u_dir_decode (
    .code  (dir),
    .valid (dec_valid),
    .dir   (dec_dir)
  );

  assign pend_tgt = step_target(pos_x_q, pos_y_q, pending_q, STEP_W, X_MAX_W, Y_MAX_W);
  assign head_tgt = step_target(pos_x_q, pos_y_q, heading_q, STEP_W, X_MAX_W, Y_MAX_W);

  always_comb begin
    state_d   = state_q;
    pending_d = dec_valid ? dec_dir : pending_q;
    heading_d = heading_q;
    qdir_d    = qdir_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    req_d     = req_q;
    moving_d  = moving_q;

    case (state_q)
      IDLE: if (frame_clk) begin
        if (pending_q != heading_q) begin
          // An out-of-range turn is treated as blocked; Q_HEAD then issues the fallback.
          state_d = Q_HEAD;
          if (!pend_tgt.oob) begin
            req_d   = 1'b1;
            qx_d    = pend_tgt.x;
            qy_d    = pend_tgt.y;
            qdir_d  = pending_q;
            state_d = Q_PEND;
          end
        end else if (head_tgt.oob) begin
          moving_d = 1'b0;
        end else begin
          req_d   = 1'b1;
          qx_d    = head_tgt.x;
          qy_d    = head_tgt.y;
          qdir_d  = heading_q;
          state_d = Q_HEAD;
        end
      end

      Q_PEND: if (q.query_ack) begin
        req_d   = 1'b0;
        state_d = q.query_blocked ? Q_HEAD : COMMIT;
      end

      Q_HEAD: begin
        if (!req_q) begin
          if (head_tgt.oob) begin
            moving_d = 1'b0;
            state_d  = IDLE;
          end else begin
            req_d  = 1'b1;
            qx_d   = head_tgt.x;
            qy_d   = head_tgt.y;
            qdir_d = heading_q;
          end
        end else if (q.query_ack) begin
          req_d = 1'b0;
          if (q.query_blocked) begin
            moving_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        pos_x_d   = qx_q;
        pos_y_d   = qy_q;
        heading_d = qdir_q;
        moving_d  = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pending_q <= LEFT;
      heading_q <= LEFT;
      qdir_q    <= LEFT;
      pos_x_q   <= 10'(X_INIT);
      pos_y_q   <= 10'(Y_INIT);
      qx_q      <= '0;
      qy_q      <= '0;
      req_q     <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      heading_q <= heading_d;
      qdir_q    <= qdir_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      req_q     <= req_d;
      moving_q  <= moving_d;
    end
  end

  assign q.query_req = req_q;
  assign q.query_x   = qx_q;
  assign q.query_y   = qy_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign heading     = heading_q;
  assign moving      = moving_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: expected lookups are queued when a tick is
// driven and compared as the mover raises each request.
module tb_ghost_mover;
  import pacman_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] dir;
  logic [9:0] pos_x, pos_y;
  dir_t       heading;
  logic       moving;

  ghost_mover_if bus ();

  ghost_mover dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .dir       (dir),
    .q         (bus),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .heading   (heading),
    .moving    (moving)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x;
    int y;
    bit blk;
  } query_t;

  query_t sb[$];
  int     total = 0;
  int     bad   = 0;

  int     m_x, m_y;
  dir_t   m_head, m_pend;
  bit     m_moving;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  function automatic bit decode(input logic [7:0] c, output dir_t d);
    bit v;
    v = 1'b1;
    d = LEFT;
    case (c)
      8'h04:   d = LEFT;
      8'h07:   d = RIGHT;
      8'h16:   d = DOWN;
      8'h1A:   d = UP;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic void model_target(input int x, input int y, input dir_t d,
                                       output bit oob, output int nx, output int ny);
    nx  = x;
    ny  = y;
    oob = 1'b0;
    case (d)
      LEFT:  begin oob = (x < 1);      nx = x - 1; end
      RIGHT: begin oob = (x + 1 > 639); nx = x + 1; end
      DOWN:  begin oob = (y + 1 > 479); ny = y + 1; end
      UP:    begin oob = (y < 1);      ny = y - 1; end
      default: oob = 1'b1;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_pos_x"},   pos_x,   m_x);
    check({tag, "_pos_y"},   pos_y,   m_y);
    check({tag, "_heading"}, heading, m_head);
    check({tag, "_moving"},  moving,  m_moving);
  endtask

  // Answers every queued lookup; optionally stalls the first ack, pulsing
  // frame_clk and changing dir while the request is held.
  task automatic serve(input int stall, input logic [7:0] mid_code);
    while (sb.size() > 0) begin
      query_t e;
      int     waited;
      e      = sb.pop_front();
      waited = 0;
      while (!bus.query_req && waited < 8) begin
        cyc();
        waited++;
      end
      check("req_seen", bus.query_req, 1'b1);
      if (!bus.query_req) begin
        sb.delete();
        break;
      end
      check("query_x", bus.query_x, e.x);
      check("query_y", bus.query_y, e.y);
      for (int i = 0; i < stall; i++) begin
        frame_clk = (i % 3 == 1);
        dir       = (i == 2) ? mid_code : 8'h00;
        cyc();
        frame_clk = 1'b0;
        dir       = 8'h00;
        check("held_req", bus.query_req, 1'b1);
        check("held_x",   bus.query_x,   e.x);
        check("held_y",   bus.query_y,   e.y);
      end
      stall             = 0;
      bus.query_ack     = 1'b1;
      bus.query_blocked = e.blk;
      cyc();
      bus.query_ack     = 1'b0;
      bus.query_blocked = 1'b0;
      check("req_drop", bus.query_req, 1'b0);
    end
  endtask

  task automatic do_step(input logic [7:0] code, input bit blk_p, input bit blk_h,
                         input int stall, input logic [7:0] mid_code, input string tag);
    bit   oob, done, first_now;
    int   nx, ny, cx, cy;
    dir_t d, cdir;
    done      = 1'b0;
    first_now = 1'b0;
    cx        = m_x;
    cy        = m_y;
    cdir      = m_head;
    if (decode(code, d)) m_pend = d;
    dir = code;
    cyc();
    dir = 8'h00;
    if (m_pend != m_head) begin
      model_target(m_x, m_y, m_pend, oob, nx, ny);
      if (!oob) begin
        sb.push_back('{nx, ny, blk_p});
        first_now = 1'b1;
        if (!blk_p) begin done = 1'b1; cx = nx; cy = ny; cdir = m_pend; end
      end
    end
    if (!done) begin
      model_target(m_x, m_y, m_head, oob, nx, ny);
      if (!oob) begin
        sb.push_back('{nx, ny, blk_h});
        if (m_pend == m_head) first_now = 1'b1;
        if (!blk_h) begin done = 1'b1; cx = nx; cy = ny; cdir = m_head; end
      end
    end
    frame_clk = 1'b1;
    cyc();
    frame_clk = 1'b0;
    check({tag, "_req_t1"}, bus.query_req, first_now);
    serve(stall, mid_code);
    cyc();
    m_x      = cx;
    m_y      = cy;
    m_head   = cdir;
    m_moving = done;
    if (decode(mid_code, d)) m_pend = d;
    check_state(tag);
  endtask

  task automatic model_reset();
    m_x      = 320;
    m_y      = 240;
    m_head   = LEFT;
    m_pend   = LEFT;
    m_moving = 1'b0;
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset             = 1'b0;
    frame_clk         = 1'b0;
    dir               = 8'h00;
    bus.query_ack     = 1'b0;
    bus.query_blocked = 1'b0;
    model_reset();

    repeat (2) cyc();
    check_state("reset");
    check("reset_req", bus.query_req, 1'b0);
    check("reset_qx",  bus.query_x,   0);
    check("reset_qy",  bus.query_y,   0);
    Reset = 1'b1;
    repeat (3) cyc();
    check_state("idle");
    check("idle_req", bus.query_req, 1'b0);

    do_step(8'h07, 1'b0, 1'b0, 0, 8'h00, "straight");
    do_step(8'h1A, 1'b1, 1'b0, 0, 8'h00, "turn_wall");
    do_step(8'h16, 1'b1, 1'b1, 0, 8'h00, "both_blk");
    do_step(8'h55, 1'b0, 1'b0, 0, 8'h00, "unknown_code");
    do_step(8'h00, 1'b0, 1'b0, 0, 8'h00, "null_code");

    do_step(8'h04, 1'b0, 1'b0, 20, 8'h1A, "stall");
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("no_extra_req", bus.query_req, 1'b0);
    end

    frame_clk = 1'b1;
    cyc();
    frame_clk = 1'b0;
    check("pre_rst_req", bus.query_req, 1'b1);
    repeat (3) cyc();
    Reset = 1'b0;
    #1;
    check("async_rst_req", bus.query_req, 1'b0);
    model_reset();
    check_state("async_rst");
    cyc();
    Reset = 1'b1;
    cyc();
    bus.query_ack = 1'b1;
    cyc();
    bus.query_ack = 1'b0;
    repeat (2) begin
      cyc();
      check("stray_ack_req", bus.query_req, 1'b0);
    end
    check_state("stray_ack");
    do_step(8'h07, 1'b0, 1'b0, 0, 8'h00, "post_rst");

    while (m_y > 0) do_step(8'h1A, 1'b0, 1'b0, 0, 8'h00, "walk_up");
    while (m_x > 0) do_step(8'h04, 1'b0, 1'b0, 0, 8'h00, "walk_left");
    do_step(8'h04, 1'b0, 1'b0, 0, 8'h00, "bound_left");
    do_step(8'h1A, 1'b0, 1'b0, 0, 8'h00, "bound_up");
    do_step(8'h16, 1'b0, 1'b0, 0, 8'h00, "leave_corner");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
